// File: rtl/tdm_pkg.sv
// Shared constants, FSM state type and lane-slice helper for the 1:8 TDM demultiplexer.
package tdm_pkg;

  localparam int NSLOT  = 8;
  localparam int SLOT_W = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // LSB position of lane k inside a packed frame of dw-bit lanes.
  function automatic int lane_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/tdm_demux_8_if.sv
// Serial slot input and parallel frame output of the TDM demultiplexer.
interface tdm_demux_8_if
  import tdm_pkg::*;
#(
  parameter int DW = 1
);

  logic [DW-1:0]       din;
  logic                din_valid;
  logic                frame_sync;
  logic [NSLOT*DW-1:0] out_bus;
  logic                frame_valid;
  logic [SLOT_W-1:0]   slot_idx;
  logic                locked;
  logic                err_sync;

  modport master (
    output din, din_valid, frame_sync,
    input  out_bus, frame_valid, slot_idx, locked, err_sync
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output out_bus, frame_valid, slot_idx, locked, err_sync
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot position counter: clear, load-1 (new frame start), increment with natural 7->0 wrap.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] idx_o,
  output logic              last_o
);

  logic [SLOT_W-1:0] idx_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (load1_i) begin
      idx_q <= SLOT_W'(1);
    end else if (inc_i) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_8.sv
// Time-division 1:8 demultiplexer: steers slots into shadow lanes and publishes whole frames atomically.
module tdm_demux_8
  import tdm_pkg::*;
#(
  parameter int DW = 1
)(
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux_8_if.slave  bus
);

  state_e state_q, state_d;

  logic [NSLOT-2:0][DW-1:0] shadow_q;
  logic [NSLOT*DW-1:0]      out_q, frame_d;
  logic                     frame_valid_q;
  logic                     err_q, err_d;
  logic                     locked_q;

  logic                     cnt_clr, cnt_load1, cnt_inc;
  logic [SLOT_W-1:0]        slot_idx;
  logic                     slot_last;
  logic                     shadow_we;
  logic [SLOT_W-1:0]        wr_idx;
  logic                     frame_done;

  tdm_slot_counter u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .idx_o   (slot_idx),
    .last_o  (slot_last)
  );

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    shadow_we  = 1'b0;
    wr_idx     = slot_idx;
    frame_done = 1'b0;
    err_d      = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_we = 1'b1;
            wr_idx    = '0;
            cnt_load1 = 1'b1;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (bus.frame_sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and restarts from this beat.
            err_d     = (slot_idx != '0);
            shadow_we = 1'b1;
            wr_idx    = '0;
            cnt_load1 = 1'b1;
          end else if (slot_idx == '0) begin
            err_d   = 1'b1;
            cnt_clr = 1'b1;
            state_d = HUNT;
          end else if (slot_last) begin
            frame_done = 1'b1;
            cnt_inc    = 1'b1;
          end else begin
            shadow_we = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Slot 7 never lands in a shadow lane; it goes straight into the published frame.
  always_comb begin
    frame_d = '0;
    for (int k = 0; k < NSLOT - 1; k++) begin
      frame_d[lane_lsb(k, DW) +: DW] = shadow_q[k];
    end
    frame_d[lane_lsb(NSLOT - 1, DW) +: DW] = bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_valid_q <= frame_done;
      err_q         <= err_d;
      locked_q      <= (state_d == RUN);
      if (frame_done) begin
        out_q <= frame_d;
      end
    end
  end

  // NOTE: the shadow lanes are a small register file with a defined reset value, so they sit under rst_n too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < NSLOT - 1; k++) begin
        if (shadow_we && (wr_idx == SLOT_W'(k))) begin
          shadow_q[k] <= bus.din;
        end
      end
    end
  end

  assign bus.out_bus     = out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.slot_idx    = slot_idx;
  assign bus.locked      = locked_q;
  assign bus.err_sync    = err_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: directed scenarios plus random traffic against a queue-based frame model.
module tb_tdm_demux_8;

  localparam int DW = 4;
  localparam int NS = 8;

  logic clk;
  logic rst_n;

  tdm_demux_8_if #(.DW(DW)) bus ();

  tdm_demux_8 #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of beats collected for the current frame.
  logic [DW-1:0]      m_beats[$];
  bit                 m_locked;
  logic [NS*DW-1:0]   m_out;
  bit                 m_fv;
  bit                 m_err;
  int                 fv_pulses;

  task automatic model_reset();
    m_beats.delete();
    m_locked = 0;
    m_out    = '0;
    m_fv     = 0;
    m_err    = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [DW-1:0] d);
    m_fv  = 0;
    m_err = 0;
    if (v) begin
      if (s) begin
        if (m_locked && m_beats.size() != 0) m_err = 1;
        m_beats.delete();
        m_beats.push_back(d);
        m_locked = 1;
      end else if (m_locked) begin
        if (m_beats.size() == 0) begin
          m_err    = 1;
          m_locked = 0;
        end else begin
          m_beats.push_back(d);
          if (m_beats.size() == NS) begin
            for (int i = 0; i < NS; i++) m_out[i*DW +: DW] = m_beats[i];
            m_beats.delete();
            m_fv = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out_bus",     64'(bus.out_bus),     64'(m_out));
    check("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
    check("slot_idx",    64'(bus.slot_idx),    64'(m_beats.size()));
    check("locked",      64'(bus.locked),      64'(m_locked));
    check("err_sync",    64'(bus.err_sync),    64'(m_err));
    if (bus.frame_valid === 1'b1) fv_pulses++;
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    @(negedge clk);
    bus.din        = d;
    bus.din_valid  = v;
    bus.frame_sync = s;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom));
  endtask

  task automatic send_frame(input logic [NS*DW-1:0] f, input int gap);
    for (int i = 0; i < NS; i++) begin
      step(1'b1, i == 0, f[i*DW +: DW]);
      if (gap > 0 && i < NS - 1) idle(gap);
    end
  endtask

  task automatic apply_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_bus",     64'(bus.out_bus),     64'(0));
    check("rst_frame_valid", 64'(bus.frame_valid), 64'(0));
    check("rst_slot_idx",    64'(bus.slot_idx),    64'(0));
    check("rst_locked",      64'(bus.locked),      64'(0));
    check("rst_err_sync",    64'(bus.err_sync),    64'(0));
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pulses_before;

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    rst_n          = 1'b1;
    fv_pulses      = 0;
    model_reset();
    apply_reset();

    // Basic frame: 1,0,1,1,0,0,1,0
    send_frame(32'h0100_1101, 0);
    check("basic_out", 64'(bus.out_bus), 64'h0100_1101);
    idle(2);

    // Gapped frame, slot_idx walks 1..7 then wraps
    pulses_before = fv_pulses;
    send_frame(32'h7654_3210, 2);
    check("gap_out", 64'(bus.out_bus), 64'h7654_3210);
    check("gap_pulses", 64'(fv_pulses - pulses_before), 64'd1);
    check("gap_wrap", 64'(bus.slot_idx), 64'd0);

    // Early sync after 5 beats of frame A
    pulses_before = fv_pulses;
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 4'hA);
    send_frame(32'h8765_4321, 0);
    check("early_out", 64'(bus.out_bus), 64'h8765_4321);
    check("early_pulses", 64'(fv_pulses - pulses_before), 64'd1);

    // Lost sync: slot-0 beat without sync, then dropped beats
    step(1'b1, 1'b0, 4'h5);
    check("lost_locked", 64'(bus.locked), 64'd0);
    check("lost_keep", 64'(bus.out_bus), 64'h8765_4321);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom));
    send_frame(32'h1357_9BDF, 1);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, DW'(i + 3));
    apply_reset();
    pulses_before = fv_pulses;
    send_frame(32'hCAFE_F00D, 0);
    check("rst_new_out", 64'(bus.out_bus), 64'hCAFE_F00D);
    check("rst_new_pulses", 64'(fv_pulses - pulses_before), 64'd1);

    // Back-to-back frames
    pulses_before = fv_pulses;
    for (int f = 0; f < 4; f++) send_frame(NS*DW'($urandom), 0);
    check("b2b_pulses", 64'(fv_pulses - pulses_before), 64'd4);

    // Random traffic: mostly well-formed frames with gaps, occasional stray syncs
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      if (m_beats.size() == 0) s = ($urandom_range(0, 7) != 0);
      else                     s = ($urandom_range(0, 19) == 0);
      step(v, s, DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
